// File: rtl/adc_trig_capture_pkg.sv
// Shared definitions for the triggered ADC capture buffer: default widths,
// trigger-edge encodings and the acquisition state encoding.
package adc_trig_capture_pkg;

    localparam int unsigned DATA_W_DEF = 12;
    localparam int unsigned ADDR_W_DEF = 10;

    localparam logic EDGE_RISING  = 1'b0;
    localparam logic EDGE_FALLING = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_PREFILL   = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_READ      = 3'd4
    } cap_state_t;

    // States in which incoming samples are written into the ring
    function automatic logic is_acquiring(input cap_state_t s);
        return (s == ST_PREFILL) || (s == ST_WAIT_TRIG) || (s == ST_POST);
    endfunction

endpackage

// File: rtl/adc_trig_capture_if.sv
// Record readout stream: valid/ready handshake carrying one sample per beat,
// with a marker on the final sample of the record.
interface adc_trig_capture_if
    import adc_trig_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) ();

    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (output out_data, output out_valid, output out_last, input out_ready);
    modport slave  (input out_data, input out_valid, input out_last, output out_ready);

endinterface

// File: rtl/adc_cap_ram.sv
// Simple dual-port sample RAM: synchronous write, registered 1-cycle read.
// Read data holds its value on cycles without a read enable.
module adc_cap_ram
    import adc_trig_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port and registered read port on the same clock
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/adc_trig_capture.sv
// Triggered capture buffer: records a DEPTH-sample window around a level
// crossing (with programmable pre-trigger length) and streams it oldest-first.
// Optional feature macro: ADC_CAP_TIMESTAMP_EN adds a free-running cycle
// counter whose value at the trigger cycle is presented on trig_time.
module adc_trig_capture
    import adc_trig_capture_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic               adc_clk,
    input  logic               sys_rst,
    input  logic [DATA_W-1:0]  adc_data,
    input  logic               arm,
    input  logic               abort,
    input  logic               force_trig,
    input  logic [DATA_W-1:0]  trig_level,
    input  logic               trig_edge,
    input  logic [ADDR_W-1:0]  pre_len,
    output logic               busy,
    output logic               done,
`ifdef ADC_CAP_TIMESTAMP_EN
    output logic [31:0]        trig_time,
`endif
    adc_trig_capture_if.master rec
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    cap_state_t        state;
    logic [DATA_W-1:0] prev;
    logic [ADDR_W-1:0] pre_q;
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] wr_cnt;
    logic [ADDR_W-1:0] post_cnt;
    logic [ADDR_W-1:0] rd_addr;
    logic [CNT_W-1:0]  rd_idx;
    logic              s1_valid;
    logic              s1_last;
    logic [DATA_W-1:0] ram_rdata;

    logic we;
    logic rd_en;
    logic advance;
    logic cross_rise;
    logic cross_fall;
    logic trig_hit;

    assign we         = is_acquiring(state);
    assign cross_rise = (prev <  trig_level) && (adc_data >= trig_level);
    assign cross_fall = (prev >= trig_level) && (adc_data <  trig_level);
    assign trig_hit   = (state == ST_WAIT_TRIG) &&
                        (force_trig || ((trig_edge == EDGE_FALLING) ? cross_fall : cross_rise));

    // Read pipeline (RAM stage + output register) advances whenever the output slot frees up
    assign advance = !rec.out_valid || rec.out_ready;
    assign rd_en   = (state == ST_READ) && advance && (rd_idx < CNT_W'(DEPTH));

    adc_cap_ram #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (adc_clk),
        .we    (we),
        .waddr (wr_ptr),
        .wdata (adc_data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_rdata)
    );

    // Previous-sample register for crossing detection, updated every cycle
    always_ff @(posedge adc_clk or posedge sys_rst) begin
        if (sys_rst) begin
            prev <= '0;
        end else begin
            prev <= adc_data;
        end
    end

    // Ring write pointer, free-running modulo DEPTH while acquiring
    always_ff @(posedge adc_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
        end else if (we) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
        end
    end

    // Acquisition/readout state machine with registered status and stream outputs
    always_ff @(posedge adc_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pre_q         <= '0;
            wr_cnt        <= '0;
            post_cnt      <= '0;
            rd_addr       <= '0;
            rd_idx        <= '0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            rec.out_data  <= '0;
            rec.out_valid <= 1'b0;
            rec.out_last  <= 1'b0;
        end else if (abort) begin
            state         <= ST_IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            rec.out_valid <= 1'b0;
            rec.out_last  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // pre_len's width already bounds it to DEPTH-1
                    if (arm) begin
                        pre_q  <= pre_len;
                        wr_cnt <= '0;
                        busy   <= 1'b1;
                        state  <= (pre_len == '0) ? ST_WAIT_TRIG : ST_PREFILL;
                    end
                end
                ST_PREFILL: begin
                    wr_cnt <= wr_cnt + ADDR_W'(1);
                    if (wr_cnt == pre_q - ADDR_W'(1)) begin
                        state <= ST_WAIT_TRIG;
                    end
                end
                ST_WAIT_TRIG: begin
                    if (trig_hit) begin
                        rd_addr  <= wr_ptr - pre_q;
                        rd_idx   <= '0;
                        post_cnt <= ADDR_W'(DEPTH - 1) - pre_q;
                        if (pre_q == ADDR_W'(DEPTH - 1)) begin
                            state <= ST_READ;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            state <= ST_POST;
                        end
                    end
                end
                ST_POST: begin
                    post_cnt <= post_cnt - ADDR_W'(1);
                    if (post_cnt == ADDR_W'(1)) begin
                        state <= ST_READ;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_READ: begin
                    if (advance) begin
                        rec.out_data  <= ram_rdata;
                        rec.out_valid <= s1_valid;
                        rec.out_last  <= s1_last;
                        s1_valid      <= rd_en;
                        s1_last       <= rd_en && (rd_idx == CNT_W'(DEPTH - 1));
                    end
                    if (rd_en) begin
                        rd_addr <= rd_addr + ADDR_W'(1);
                        rd_idx  <= rd_idx + CNT_W'(1);
                    end
                    if (rec.out_valid && rec.out_ready && rec.out_last) begin
                        state         <= ST_IDLE;
                        done          <= 1'b0;
                        s1_valid      <= 1'b0;
                        rec.out_valid <= 1'b0;
                        rec.out_last  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef ADC_CAP_TIMESTAMP_EN
    logic [31:0] ts_cnt;

    // Free-running timestamp; captured on the trigger cycle and held
    always_ff @(posedge adc_clk or posedge sys_rst) begin
        if (sys_rst) begin
            ts_cnt    <= '0;
            trig_time <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (trig_hit && !abort) begin
                trig_time <= ts_cnt;
            end
        end
    end
`endif

endmodule

// File: tb/tb_adc_trig_capture.sv
// Bench for adc_trig_capture: directed acquisitions checked every cycle against
// a record/window model derived from the driven waveform, plus literal pins.
// Timestamp checks are included when ADC_CAP_TIMESTAMP_EN is defined.
module tb_adc_trig_capture;

    localparam int DEPTH = 1024;
    localparam int NW    = 8192;

    logic        clk;
    logic        rst;
    logic [11:0] adc_data;
    logic        arm;
    logic        abort;
    logic        force_trig;
    logic [11:0] trig_level;
    logic        trig_edge;
    logic [9:0]  pre_len;
    logic        busy;
    logic        done;
`ifdef ADC_CAP_TIMESTAMP_EN
    logic [31:0] trig_time;
`endif

    adc_trig_capture_if rec ();

    adc_trig_capture dut (
        .adc_clk    (clk),
        .sys_rst    (rst),
        .adc_data   (adc_data),
        .arm        (arm),
        .abort      (abort),
        .force_trig (force_trig),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .pre_len    (pre_len),
        .busy       (busy),
        .done       (done),
`ifdef ADC_CAP_TIMESTAMP_EN
        .trig_time  (trig_time),
`endif
        .rec        (rec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Per-test model state shared with the compare process
    logic [11:0] wave    [NW];
    logic [11:0] exp_rec [DEPTH];
    logic [11:0] got     [DEPTH];
    int  cyc, exp_t, r_cyc, busy_end, abort_k;
    int  beats, first_cyc, fin_cyc, last_idx;
    bit  active, finished, stall_prev;
    logic [11:0] held_data;
    logic        held_last;
    int unsigned edge_cnt = 0;
    logic [31:0] tt_prev = 32'd0;
    logic [31:0] tt_at_trig = 32'd0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // First cycle (>= start of WAIT_TRIG) meeting the trigger rule
    function automatic int find_trig(input int pre, input logic [11:0] lvl,
                                     input logic fall, input int fk);
        for (int c = pre + 1; c < NW; c++) begin
            if (c == fk) return c;
            if (!fall && wave[c-1] <  lvl && wave[c] >= lvl) return c;
            if ( fall && wave[c-1] >= lvl && wave[c] <  lvl) return c;
        end
        return -1;
    endfunction

    always @(posedge clk) if (!rst) edge_cnt++;

    // Compare process: status windows, stream contents, stall stability
    always @(negedge clk) begin : cmp
        bit busy_e, done_e;
        if (active) begin
            busy_e = (cyc >= 1) && (cyc <= busy_end);
            done_e = (cyc >= r_cyc) && (abort_k < 0 || cyc <= abort_k) && !finished;
            chk("busy", 32'(busy), 32'(busy_e));
            chk("done", 32'(done), 32'(done_e));
            if (!done_e) chk("valid_outside_read", 32'(rec.out_valid), 32'd0);
            if (stall_prev) begin
                chk("stall_valid", 32'(rec.out_valid), 32'd1);
                chk("stall_data", 32'(rec.out_data), 32'(held_data));
                chk("stall_last", 32'(rec.out_last), 32'(held_last));
            end
            if (done_e && beats == 0 && cyc == r_cyc + 2)
                chk("first_valid_latency", 32'(rec.out_valid), 32'd1);
`ifdef ADC_CAP_TIMESTAMP_EN
            chk("trig_time", trig_time, (cyc > exp_t) ? tt_at_trig : tt_prev);
`endif
            if (rec.out_valid && rec.out_ready && beats < DEPTH) begin
                chk("beat_data", 32'(rec.out_data), 32'(exp_rec[beats]));
                chk("beat_last", 32'(rec.out_last), 32'(beats == DEPTH - 1));
                got[beats] = rec.out_data;
                if (rec.out_last) last_idx = beats;
                if (beats == 0) first_cyc = cyc;
                beats++;
                if (beats == DEPTH) begin
                    finished = 1'b1;
                    fin_cyc  = cyc;
                end
            end
            stall_prev = rec.out_valid && !rec.out_ready;
            held_data  = rec.out_data;
            held_last  = rec.out_last;
        end
    end

    // One acquisition: model the window, then drive cycle by cycle from arm (k=0)
    task automatic run_test(input int pre, input logic [11:0] lvl, input logic fall,
                            input int fk, input int abk, input bit rnd_ready);
        int post;
        bit ok;
        post  = DEPTH - 1 - pre;
        exp_t = find_trig(pre, lvl, fall, fk);
        for (int i = 0; i < DEPTH; i++) exp_rec[i] = wave[exp_t - pre + i];
        r_cyc    = exp_t + post + 1;
        busy_end = (abk >= 0 && abk < exp_t + post) ? abk : exp_t + post;
        abort_k  = abk;
        beats = 0; finished = 1'b0; stall_prev = 1'b0;
        first_cyc = -1; fin_cyc = -1; last_idx = -1;
        tt_at_trig = 32'(edge_cnt) + 32'(exp_t);
        pre_len = 10'(pre); trig_level = lvl; trig_edge = fall;
        ok = 1'b0;
        active = 1'b1;
        for (int k = 0; k < 12000; k++) begin
            cyc        = k;
            adc_data   = (k < NW) ? wave[k] : 12'h000;
            arm        = (k == 0) || (k == abk);
            abort      = (k == abk);
            force_trig = (k == fk);
            rec.out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            if ((finished && k > fin_cyc + 3) || (abk >= 0 && k > abk + 60)) begin
                ok = 1'b1;
                break;
            end
        end
        active = 1'b0;
        arm = 1'b0; abort = 1'b0; force_trig = 1'b0; rec.out_ready = 1'b1;
        chk("test_completed", 32'(ok), 32'd1);
        tt_prev = tt_at_trig;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; adc_data = '0; arm = 1'b0; abort = 1'b0; force_trig = 1'b0;
        trig_level = '0; trig_edge = 1'b0; pre_len = '0; rec.out_ready = 1'b1;
        active = 1'b0; cyc = 0; exp_t = 0; r_cyc = 0; busy_end = 0; abort_k = -1;

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_valid", 32'(rec.out_valid), 32'd0);
        chk("rst_last", 32'(rec.out_last), 32'd0);
        chk("rst_data", 32'(rec.out_data), 32'd0);
`ifdef ADC_CAP_TIMESTAMP_EN
        chk("rst_trig_time", trig_time, 32'd0);
`endif
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // 1: ramp, rising through 0x800, pre_len 100
        for (int k = 0; k < NW; k++) wave[k] = 12'(k);
        run_test(100, 12'h800, 1'b0, -1, -1, 1'b0);
        chk("t1_trig_cycle", 32'(exp_t), 32'd2048);
        chk("t1_idx100", 32'(got[100]), 32'h800);
        chk("t1_idx99", 32'(got[99]), 32'h7FF);
        chk("t1_last_idx", 32'(last_idx), 32'd1023);
        chk("t1_back_to_back", 32'(fin_cyc - first_cyc), 32'd1023);

        // 2: constant 0x100, force trigger, pre_len 0
        for (int k = 0; k < NW; k++) wave[k] = 12'h100;
        run_test(0, 12'h800, 1'b0, 5, -1, 1'b0);
        chk("t2_trig_cycle", 32'(exp_t), 32'd5);
        chk("t2_idx0", 32'(got[0]), 32'h100);
        chk("t2_idx1023", 32'(got[1023]), 32'h100);
        chk("t2_beats", 32'(beats), 32'd1024);

        // 3: sine, falling edge, pre_len 1023 (no POST phase)
        for (int k = 0; k < NW; k++)
            wave[k] = 12'($rtoi(2048.0 + 1800.0 * $sin(2.0 * 3.14159265358979 * k / 256.0)));
        run_test(1023, 12'h800, 1'b1, -1, -1, 1'b0);
        chk("t3_trig_below_level", 32'(got[1023] < 12'h800), 32'd1);
        chk("t3_prev_at_or_above", 32'(got[1022] >= 12'h800), 32'd1);

        // 4: stepped ramp, rising through 0x300, pre_len 37, random ready
        for (int k = 0; k < NW; k++) wave[k] = 12'(k * 7);
        run_test(37, 12'h300, 1'b0, -1, -1, 1'b1);
        chk("t4_trig_cycle", 32'(exp_t), 32'd110);
        chk("t4_idx37", 32'(got[37]), 32'h302);
        chk("t4_idx36", 32'(got[36]), 32'h2FB);
        chk("t4_beats", 32'(beats), 32'd1024);

        // 5: abort together with arm during POST
        for (int k = 0; k < NW; k++) wave[k] = 12'(k);
        run_test(10, 12'hFFF, 1'b0, 20, 30, 1'b0);
        chk("t5_no_beats", 32'(beats), 32'd0);
        chk("t5_idle_busy", 32'(busy), 32'd0);
        chk("t5_idle_done", 32'(done), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_trig_capture.md
# adc_trig_capture

Triggered capture buffer directly downstream of the ADS412x driver: consumes its 12-bit offset-corrected sample stream (one sample per `adc_clk`), records a fixed-depth window around a level-crossing trigger, including a programmable pre-trigger section, then streams the record out oldest-first over a valid/ready handshake. It provides the scope-style acquisition path between the ADC front end and the host readout logic.

## Interface
- `DATA_W`, 12, sample width; matches driver output
- `ADDR_W`, 10, buffer address width; DEPTH = 2**ADDR_W samples per record
- `adc_clk`  in  1  sample clock; the only clock
- `sys_rst`  in  1  reset, asynchronous, active-high
- `adc_data`  in  DATA_W  sample, valid every cycle, unsigned
- `arm`  in  1  start acquisition; honoured in IDLE only
- `abort`  in  1  return to IDLE from any state
- `force_trig`  in  1  unconditional trigger; honoured in WAIT_TRIG only
- `trig_level`  in  DATA_W  unsigned threshold
- `trig_edge`  in  1  0 = rising, 1 = falling
- `pre_len`  in  ADDR_W  pre-trigger samples; sampled at `arm`
- `busy`  out  1  high in PREFILL, WAIT_TRIG, POST
- `done`  out  1  high in READ
- `out_data`  out  DATA_W  record sample
- `out_valid`  out  1  `out_data` valid
- `out_ready`  in  1  consumer accepts
- `out_last`  out  1  marks sample DEPTH-1 of the record
- `trig_time`  out  32  trigger timestamp; present only with ADC_CAP_TIMESTAMP_EN

## Operation
- States: IDLE, PREFILL, WAIT_TRIG, POST, READ.
- IDLE: no writes. On `arm`, latch `pre_len` (clamped to DEPTH-1), reset `wr_cnt`, go PREFILL; if latched `pre_len` = 0, go WAIT_TRIG directly.
- PREFILL: write every sample at `wr_ptr` (wraps mod DEPTH); after `pre_len` writes, go WAIT_TRIG. Triggers ignored.
- WAIT_TRIG: keep writing (ring). Crossing uses `prev` = previous cycle's `adc_data`, registered every cycle: rising `prev < trig_level && adc_data >= trig_level`; falling `prev >= trig_level && adc_data < trig_level`. On crossing or `force_trig`, the current sample is the trigger sample: write it, record `start_addr = trig_addr - pre_len` (mod DEPTH), go POST with `post_cnt` = DEPTH-1-pre_len.
- POST: write `post_cnt` further samples, then go READ; if `post_cnt` = 0, go READ the cycle after trigger.
- READ: stream DEPTH samples from `start_addr` upward, wrapping; trigger sample is at record index `pre_len`. `out_last` on index DEPTH-1; after the last handshake, go IDLE.
- `abort` wins over every other input, including simultaneous `arm`; output stream drops mid-record (`out_valid` low next cycle).
- Buffer contents outside the recorded window are don't-care; no RAM reset.

## Timing
- Reset values: state IDLE; `busy`, `done`, `out_valid`, `out_last` 0; `out_data` 0; `prev` 0; `trig_time` 0.
- `arm` at cycle n: first sample written at n+1.
- Trigger detected on cycle t: POST entered at t+1; READ entered at t+1+`post_cnt`.
- READ entry to first `out_valid`: at most 2 cycles (RAM read latency 1 plus output register).
- AXI-style handshake: transfer when `out_valid && out_ready`; `out_data`/`out_last` held stable while `out_valid && !out_ready`; sustained one beat per cycle when `out_ready` is held high.
- No write/read address collision: writes stop before READ.

## Configuration
- `ADC_CAP_TIMESTAMP_EN` defined: free-running 32-bit counter, cleared by `sys_rst` and wrapping at 2^32; value latched into `trig_time` on the trigger cycle and held until the next trigger.
- Not defined: no counter and no `trig_time` port; all other behaviour identical.

## Structure
- Shared package: state encoding, `DATA_W`/`ADDR_W` defaults, trigger-edge constants.
- One sub-module, `adc_cap_ram`: simple dual-port RAM, DEPTH x DATA_W, synchronous write, 1-cycle registered read, same clock.

## Test plan
- Ramp 0..4095, `trig_level` 0x800, rising, `pre_len` 100 -> record index 100 = 0x800, index 99 = 0x7FF, `out_last` on beat 1023.
- Constant 0x100, `force_trig` in WAIT_TRIG, `pre_len` 0 -> no PREFILL; 1024 beats of 0x100; trigger at index 0.
- Falling edge, sine input, `pre_len` 1023 -> READ entered the cycle after trigger; last sample = trigger sample < level.
- Random `out_ready` during READ -> data and `out_last` stable while stalled; exactly 1024 transfers, in order.
- `abort` asserted with `arm` during POST -> IDLE next cycle, `busy` 0, and no `out_valid`.
- With `ADC_CAP_TIMESTAMP_EN`, trigger at 500 cycles after reset release -> `trig_time` = 500 ± fixed pipeline offset, constant until the next trigger.
